// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// State encoding, op encoding and bus geometry.
package dmem_pkg;

  localparam int DMEM_ADDR_W     = 20;
  localparam int DMEM_WORD_W     = 16;
  localparam int DMEM_DEPTH_LOG2 = 12;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    RESP
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage to data-memory request/response bundle.
// master = memory stage, slave = responder.
interface data_mem_responder_if #(
  parameter int ADDR_W = 20
);

  logic              i_memRead;
  logic              i_memWrite;
  logic              i_en32;
  logic [ADDR_W-1:0] i_address;
  logic [31:0]       i_data_in;
  logic [31:0]       o_data_out;
  logic              o_busy;
  logic              o_done;
  logic              o_addrErr;

  modport master (
    output i_memRead,
    output i_memWrite,
    output i_en32,
    output i_address,
    output i_data_in,
    input  o_data_out,
    input  o_busy,
    input  o_done,
    input  o_addrErr
  );

  modport slave (
    input  i_memRead,
    input  i_memWrite,
    input  i_en32,
    input  i_address,
    input  i_data_in,
    output o_data_out,
    output o_busy,
    output o_done,
    output o_addrErr
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Single-port synchronous word RAM, registered read, no reset.
// Read returns the pre-write contents on a write cycle.
module mem_word_array #(
  parameter int DEPTH_LOG2 = 12,
  parameter int WORD_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 16/32-bit requests served one word per beat
// from a single-port word array, with busy stall and done pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
  parameter int WORD_W     = DMEM_WORD_W
) (
  input  logic          clk,
  input  logic          i_reset,
  data_mem_responder_if.slave bus
);

  typedef logic [DEPTH_LOG2-1:0] waddr_t;
  typedef logic [WORD_W-1:0]     word_t;

  state_e state;
  state_e stateNext;

  waddr_t      addrQ;
  logic [31:0] dataQ;
  op_e         opQ;
  logic        en32Q;
  logic        errQ;
  word_t       hiQ;
  logic [31:0] dataOut;

  logic req;
  logic reqErr;
  logic accept;

  logic   ramWe;
  waddr_t ramAddr;
  word_t  ramWdata;
  word_t  ramRdata;

  logic busy;
  logic done;
  logic addrErr;

  assign req    = bus.i_memRead | bus.i_memWrite;
  assign reqErr = (bus.i_memRead & bus.i_memWrite)
                | (|bus.i_address[ADDR_W-1:DEPTH_LOG2]);
  assign accept = (state == IDLE) & req & ~i_reset;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          stateNext = reqErr ? RESP : FIRST;
        end
      end
      FIRST: begin
        stateNext = en32Q ? SECOND : RESP;
      end
      SECOND: begin
        stateNext = RESP;
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Reads are fetched one beat ahead: the RAM sees the request address
  // in the accept cycle and addr+1 in FIRST, so each word lands in time
  // for o_data_out to be valid in RESP.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    addrErr  = 1'b0;
    ramWe    = 1'b0;
    ramAddr  = bus.i_address[DEPTH_LOG2-1:0];
    ramWdata = dataQ[15:0];
    unique case (state)
      IDLE: begin
        busy = req;
      end
      FIRST: begin
        busy     = 1'b1;
        ramWe    = (opQ == OP_WR);
        ramAddr  = (opQ == OP_WR) ? addrQ : addrQ + 1'b1;
        ramWdata = en32Q ? dataQ[31:16] : dataQ[15:0];
      end
      SECOND: begin
        busy     = 1'b1;
        ramWe    = (opQ == OP_WR);
        ramAddr  = addrQ + 1'b1;
        ramWdata = dataQ[15:0];
      end
      RESP: begin
        done    = 1'b1;
        addrErr = errQ;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    if (i_reset) begin
      busy  = 1'b0;
      ramWe = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      addrQ   <= '0;
      dataQ   <= '0;
      opQ     <= OP_RD;
      en32Q   <= 1'b0;
      errQ    <= 1'b0;
      hiQ     <= '0;
      dataOut <= '0;
    end else begin
      if (accept) begin
        addrQ <= bus.i_address[DEPTH_LOG2-1:0];
        dataQ <= bus.i_data_in;
        opQ   <= bus.i_memWrite ? OP_WR : OP_RD;
        en32Q <= bus.i_en32;
        errQ  <= reqErr;
      end
      if (state == FIRST && opQ == OP_RD) begin
        if (en32Q) begin
          hiQ <= ramRdata;
        end else begin
          dataOut <= {{(32-WORD_W){1'b0}}, ramRdata};
        end
      end
      if (state == SECOND && opQ == OP_RD) begin
        dataOut <= {hiQ, ramRdata};
      end
    end
  end

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WORD_W    (WORD_W)
  ) u_array (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

  assign bus.o_data_out = dataOut;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_addrErr  = addrErr;

endmodule
